// File: rtl/zl_punct_conv_encoder.sv
`default_nettype none
// ============================================================================
// zl_punct_conv_encoder : rate-1/2 convolutional encoder with a runtime
//                         selectable DVB-S puncturer (1/2 2/3 3/4 5/6 7/8).
// Revision 1.0
// ============================================================================
module zl_punct_conv_encoder #(
  parameter int             K      = 7,
  parameter logic [K-1:0]   I_POLY = 7'o171,
  parameter logic [K-1:0]   Q_POLY = 7'o133,
  parameter int             DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync_clr,
  input  logic [2:0]        rate_sel,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_req,
  output logic              data_in_ack,
  output logic              data_out_i,
  output logic              data_out_q,
  output logic              data_out_req,
  input  logic              data_out_ack
);

  localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic [K-2:0]     sr;
  logic [IDX_W-1:0] bit_idx;
  logic [2:0]       phase;
  logic [2:0]       rate;
  logic             rate_fresh;
  logic [2:0]       bbuf;
  logic [1:0]       cnt;

  logic [2:0]       eff_rate;
  logic [2:0]       period;
  logic [2:0]       nphase;
  logic             keep_x;
  logic             keep_y;
  logic             cur_bit;
  logic [K-1:0]     vec;
  logic             enc_x;
  logic             enc_y;
  logic             pop;
  logic [1:0]       rem;
  logic             step;
  logic             bit_a;
  logic             two_kept;
  logic [1:0]       nkept;
  logic [2:0]       nbuf;
  logic [1:0]       ncnt;

  // After an asynchronous reset the active rate is taken from rate_sel
  // until the first clock edge latches it.
  assign eff_rate = rate_fresh ? rate_sel : rate;

  always_comb begin
    period = 3'd1;
    keep_x = 1'b1;
    keep_y = 1'b1;
    case (eff_rate)
      3'd1: begin
        period = 3'd2;
        keep_x = (phase == 3'd0);
      end
      3'd2: begin
        period = 3'd3;
        keep_x = (phase != 3'd1);
        keep_y = (phase != 3'd2);
      end
      3'd3: begin
        period = 3'd5;
        keep_x = ~phase[0];
        keep_y = (phase == 3'd0) || (phase == 3'd1) || (phase == 3'd3);
      end
      3'd4: begin
        period = 3'd7;
        keep_x = (phase == 3'd0) || (phase == 3'd4) || (phase == 3'd6);
        keep_y = (phase != 3'd4) && (phase != 3'd6);
      end
      default: begin
        period = 3'd1;
      end
    endcase
  end

  assign nphase  = (phase == period - 3'd1) ? 3'd0 : phase + 3'd1;

  assign cur_bit = data_in[bit_idx];
  assign vec     = {cur_bit, sr};
  assign enc_x   = ^(vec & I_POLY);
  assign enc_y   = ^(vec & Q_POLY);

  assign data_out_req = cnt[1];
  assign data_out_i   = data_out_req & bbuf[0];
  assign data_out_q   = data_out_req & bbuf[1];

  assign pop         = data_out_req & data_out_ack;
  assign rem         = pop ? cnt - 2'd2 : cnt;
  assign step        = rst_n & ~sync_clr & data_in_req & (rem <= 2'd1);
  assign data_in_ack = step & (bit_idx == '0);

  // Kept bits go in X-then-Y order directly after the bits left over from the pop.
  assign bit_a    = keep_x ? enc_x : enc_y;
  assign two_kept = keep_x & keep_y;
  assign nkept    = {1'b0, keep_x} + {1'b0, keep_y};

  always_comb begin
    nbuf = pop ? {2'b00, bbuf[2]} : bbuf;
    ncnt = rem;
    if (step) begin
      ncnt = rem + nkept;
      if (rem[0]) begin
        nbuf[1] = bit_a;
        if (two_kept) nbuf[2] = enc_y;
      end else begin
        nbuf[0] = bit_a;
        if (two_kept) nbuf[1] = enc_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      bit_idx    <= LAST_IDX;
      phase      <= 3'd0;
      rate       <= 3'd0;
      rate_fresh <= 1'b1;
      bbuf       <= 3'b000;
      cnt        <= 2'd0;
    end else if (sync_clr) begin
      sr         <= '0;
      bit_idx    <= LAST_IDX;
      phase      <= 3'd0;
      rate       <= rate_sel;
      rate_fresh <= 1'b0;
      bbuf       <= 3'b000;
      cnt        <= 2'd0;
    end else begin
      rate_fresh <= 1'b0;
      // A new rate only takes hold on a pattern boundary.
      if (rate_fresh || (step && (nphase == 3'd0))) rate <= rate_sel;
      bbuf <= nbuf;
      cnt  <= ncnt;
      if (step) begin
        sr      <= vec[K-1:1];
        bit_idx <= (bit_idx == '0) ? LAST_IDX : bit_idx - 1'b1;
        phase   <= nphase;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zl_punct_conv_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// Directed table-driven bench for zl_punct_conv_encoder: impulse-style words at
// every rate, with and without output backpressure, plus reset/clear sequences.
module tb_zl_punct_conv_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync_clr;
  logic [2:0] rate_sel;
  logic [7:0] data_in;
  logic       data_in_req;
  logic       data_in_ack;
  logic       data_out_i;
  logic       data_out_q;
  logic       data_out_req;
  logic       data_out_ack;

  always #5 clk = ~clk;

  zl_punct_conv_encoder #(
    .K      (7),
    .I_POLY (7'o171),
    .Q_POLY (7'o133),
    .DATA_W (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sync_clr     (sync_clr),
    .rate_sel     (rate_sel),
    .data_in      (data_in),
    .data_in_req  (data_in_req),
    .data_in_ack  (data_in_ack),
    .data_out_i   (data_out_i),
    .data_out_q   (data_out_q),
    .data_out_req (data_out_req),
    .data_out_ack (data_out_ack)
  );

  typedef struct {
    logic [2:0]  rate;
    logic [7:0]  w0;
    logic [7:0]  w1;
    int          npairs;
    logic [15:0] ei;      // expected I bit of pair n at bit n
    logic [15:0] eq;
    int          ack_pct;
    int          chg_cycle;
    logic [2:0]  chg_rate;
    bit          tchk;    // check ack/latency cycle positions
  } vec_t;

  vec_t vecs[12];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic [2:0] r, input logic [7:0] a, input logic [7:0] b,
                              input int n, input logic [15:0] ei, input logic [15:0] eq,
                              input int pct, input int cc, input logic [2:0] cr, input bit t);
    vec_t v;
    v.rate = r; v.w0 = a; v.w1 = b; v.npairs = n; v.ei = ei; v.eq = eq;
    v.ack_pct = pct; v.chg_cycle = cc; v.chg_rate = cr; v.tchk = t;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_sync(input logic [2:0] r);
    @(negedge clk);
    rate_sel     = r;
    sync_clr     = 1'b1;
    data_in_req  = 1'b0;
    data_out_ack = 1'b0;
    @(negedge clk);
    sync_clr = 1'b0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [15:0] gi, gq;
    logic [7:0]  words[2];
    int          np, nack, widx, first_req;
    int          ack_cyc[2];
    logic        held, hi, hq;
    clear_sync(v.rate);
    words[0] = v.w0; words[1] = v.w1;
    gi = '0; gq = '0; np = 0; nack = 0; widx = 0; first_req = -1;
    ack_cyc[0] = -1; ack_cyc[1] = -1; held = 1'b0; hi = 1'b0; hq = 1'b0;
    for (int cyc = 0; cyc < 250; cyc++) begin
      @(negedge clk);
      if (cyc == v.chg_cycle) rate_sel = v.chg_rate;
      data_in_req  = (widx < 2);
      data_in      = (widx < 2) ? words[widx] : 8'h00;
      data_out_ack = ($urandom_range(99) < v.ack_pct);
      #1;
      if (held) check($sformatf("hold v%0d", id), {29'd0, data_out_req, data_out_i, data_out_q},
                      {29'd0, 1'b1, hi, hq});
      held = data_out_req && !data_out_ack;
      hi = data_out_i; hq = data_out_q;
      if (data_out_req && first_req < 0) first_req = cyc;
      if (data_out_req && data_out_ack) begin
        if (np < 16) begin gi[np] = data_out_i; gq[np] = data_out_q; end
        np++;
      end
      if (data_in_ack) begin
        if (nack < 2) ack_cyc[nack] = cyc;
        nack++;
        widx++;
      end
    end
    data_in_req = 1'b0;
    check($sformatf("pairs v%0d", id), np, v.npairs);
    check($sformatf("I v%0d", id), {16'd0, gi}, {16'd0, v.ei});
    check($sformatf("Q v%0d", id), {16'd0, gq}, {16'd0, v.eq});
    check($sformatf("words v%0d", id), nack, 2);
    if (v.tchk) begin
      check($sformatf("ack1 cyc v%0d", id), ack_cyc[0], 7);
      check($sformatf("ack2 cyc v%0d", id), ack_cyc[1], 15);
      check($sformatf("latency v%0d", id), first_req, 1);
    end
  endtask

  initial begin
    // Impulse responses: X=1111001.., Y=1011011.. punctured per rate.
    vecs[0]  = mk(3'd0, 8'h80, 8'h00, 16, 16'h004F, 16'h006D, 100, -1, 3'd0, 1'b1);
    vecs[1]  = mk(3'd1, 8'h80, 8'h00, 12, 16'h0035, 16'h0017, 100, -1, 3'd0, 1'b0);
    vecs[2]  = mk(3'd2, 8'h80, 8'h00, 11, 16'h0015, 16'h0017, 100, -1, 3'd0, 1'b0);
    vecs[3]  = mk(3'd3, 8'h80, 8'h00, 10, 16'h0015, 16'h000B, 100, -1, 3'd0, 1'b0);
    vecs[4]  = mk(3'd4, 8'h80, 8'h00,  9, 16'h000D, 16'h000B, 100, -1, 3'd0, 1'b0);
    vecs[5]  = mk(3'd6, 8'h80, 8'h00, 16, 16'h004F, 16'h006D, 100, -1, 3'd0, 1'b1);
    vecs[6]  = mk(3'd0, 8'h80, 8'h00, 16, 16'h004F, 16'h006D,  30, -1, 3'd0, 1'b0);
    vecs[7]  = mk(3'd2, 8'h80, 8'h00, 11, 16'h0015, 16'h0017,  30, -1, 3'd0, 1'b0);
    vecs[8]  = mk(3'd4, 8'h80, 8'h00,  9, 16'h000D, 16'h000B,  30, -1, 3'd0, 1'b0);
    vecs[9]  = mk(3'd0, 8'hC0, 8'h00, 16, 16'h00D1, 16'h00B7,  30, -1, 3'd0, 1'b0);
    vecs[10] = mk(3'd2, 8'hC0, 8'h00, 11, 16'h003B, 16'h0001,  30, -1, 3'd0, 1'b0);
    // 3/4 switched to 1/2 during phase 1: new rate starts on step 3.
    vecs[11] = mk(3'd2, 8'h80, 8'h00, 15, 16'h0025, 16'h0037, 100,  1, 3'd0, 1'b0);

    rst_n = 1'b0; sync_clr = 1'b0; rate_sel = 3'd0; data_in = 8'h00;
    data_in_req = 1'b0; data_out_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset outputs", {28'd0, data_out_req, data_out_i, data_out_q, data_in_ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Partial word of ones then sync_clr: impulse must come out clean.
    clear_sync(3'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      data_in = 8'hFF; data_in_req = 1'b1; data_out_ack = 1'b1;
    end
    run_vec(12, vecs[0]);

    // Asynchronous reset mid-run with a pending pair.
    clear_sync(3'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      data_in = 8'hFF; data_in_req = 1'b1; data_out_ack = 1'b0;
    end
    #1;
    check("req before rst", {31'd0, data_out_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst mid-run", {28'd0, data_out_req, data_out_i, data_out_q, data_in_ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    data_in_req = 1'b0;
    run_vec(13, vecs[2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
